// File: rtl/uart_pkg.sv
// Shared UART_System constants: byte width, TX FIFO state encoding and control register bit map.
package uart_pkg;

    localparam int   UART_DATA_W    = 8;
    localparam logic ST_IDLE        = 1'b0;
    localparam logic ST_WAIT        = 1'b1;
    localparam int   CTRL_TX_EN_BIT = 0;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO: storage array, wrapping pointers and an occupancy count that alone drives full/empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Next pointer and count values; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: one tx_start per byte, next byte only after tx_done.
// Optional tx_done watchdog enabled by defining UART_TX_FIFO_TIMEOUT_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W         = UART_DATA_W,
    parameter  int DEPTH          = 16,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              tx_timeout
);

    tx_state_e           state_q, state_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   head_s;
    logic                full_s;
    logic                empty_s;
    logic                pop_s;
    logic                wd_fire_s;
    logic                tx_en_s;
    logic [CTRL_TX_EN_BIT:0] ctrl_s;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (wr_en),
        .pop_i     (pop_s),
        .wr_data_i (wr_data),
        .rd_data_o (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .level_o   (level)
    );

    // tx_en is the enable bit of the host control register.
    always_comb begin
        ctrl_s                 = '0;
        ctrl_s[CTRL_TX_EN_BIT] = tx_en;
    end
    assign tx_en_s = ctrl_s[CTRL_TX_EN_BIT];

    // Transmit FSM: pop and pulse tx_start from IDLE, then hold until tx_done or watchdog expiry.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en_s && !empty_s) begin
                    pop_s      = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = head_s;
                    state_d    = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (tx_done || wd_fire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky overflow: a dropped push in the same cycle as clr_ovf keeps the flag set.
    always_comb begin
        if (wr_en && full_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FSM state and registered transmitter-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // The count is zero in IDLE, so every entry to WAIT starts a fresh window.
    assign wd_fire_s = (state_q == S_WAIT) && !tx_done && (wd_cnt_q == WD_LAST);

    // Watchdog count and sticky timeout flag.
    always_comb begin
        if (state_q == S_WAIT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = '0;
        end
        if (wd_fire_s) begin
            timeout_d = 1'b1;
        end else if (clr_ovf) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_timeout = timeout_q;
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 0);
    assign wd_fire_s            = 1'b0;
    assign tx_timeout           = 1'b0;
`endif

    assign full     = full_s;
    assign empty    = empty_s;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != S_IDLE);

endmodule
